// File: rtl/frac_cen_gen.sv
// Fractional clock-enable generator: per-channel num/den pulse trains
// gated by a PLL lock/settle state machine, with a ready/valid config port.
module frac_cen_gen #(
   parameter int CHANNELS      = 2,
   parameter int ACC_W         = 16,
   parameter int SETTLE_CYCLES = 1024,
   parameter int DEF_DEN       = 16,
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                refclk,
   input  logic                rst,
   input  logic                pll_locked_in,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CW-1:0]       cfg_chan,
   input  logic [ACC_W-1:0]    cfg_num,
   input  logic [ACC_W-1:0]    cfg_den,
   output logic [CHANNELS-1:0] cen,
   output logic                locked
);

   localparam int SW = $clog2(SETTLE_CYCLES) + 1;
   localparam logic [SW-1:0] LAST = SW'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      SETTLE    = 2'd1,
      RUN       = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [SW-1:0]      cnt_q, cnt_d;
   logic               locked_q, locked_d;
   logic               cfg_ready_q, cfg_ready_d;
   logic [CHANNELS-1:0] cen_q, cen_d;

   logic [ACC_W-1:0]   num_q [CHANNELS];
   logic [ACC_W-1:0]   num_d [CHANNELS];
   logic [ACC_W-1:0]   den_q [CHANNELS];
   logic [ACC_W-1:0]   den_d [CHANNELS];
   logic [ACC_W-1:0]   acc_q [CHANNELS];
   logic [ACC_W-1:0]   acc_d [CHANNELS];
   logic [ACC_W:0]     sum   [CHANNELS];

   logic cfg_fire;
   logic run_go;

   assign cfg_fire = cfg_valid & cfg_ready_q;
   // Accumulate only while RUN persists; a lock drop edge clears instead.
   assign run_go   = (state_q == RUN) & pll_locked_in;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         WAIT_LOCK: begin
            if (pll_locked_in) begin
               state_d = SETTLE;
               cnt_d   = '0;
            end
         end
         SETTLE: begin
            if (!pll_locked_in) begin
               state_d = WAIT_LOCK;
            end else if (cnt_q == LAST) begin
               state_d = RUN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RUN: begin
            if (!pll_locked_in) state_d = WAIT_LOCK;
         end
         default: state_d = WAIT_LOCK;
      endcase
      locked_d    = (state_d == RUN);
      cfg_ready_d = ~cfg_fire;
   end

   always_comb begin
      cen_d = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         num_d[i] = num_q[i];
         den_d[i] = den_q[i];
         acc_d[i] = '0;
         sum[i]   = {1'b0, acc_q[i]} + {1'b0, num_q[i]};
         if (cfg_fire && (cfg_chan == CW'(i))) begin
            num_d[i] = cfg_num;
            den_d[i] = cfg_den;
         end else if (run_go && (num_q[i] != '0) && (den_q[i] != '0)) begin
            if (num_q[i] >= den_q[i]) begin
               cen_d[i] = 1'b1;
            end else if (sum[i] >= {1'b0, den_q[i]}) begin
               // Result is < den, so modular ACC_W-bit subtraction is exact.
               acc_d[i] = sum[i][ACC_W-1:0] - den_q[i];
               cen_d[i] = 1'b1;
            end else begin
               acc_d[i] = sum[i][ACC_W-1:0];
            end
         end
      end
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_q     <= WAIT_LOCK;
         cnt_q       <= '0;
         locked_q    <= 1'b0;
         cfg_ready_q <= 1'b0;
         cen_q       <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            num_q[i] <= ACC_W'(1);
            den_q[i] <= ACC_W'(DEF_DEN);
            acc_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         locked_q    <= locked_d;
         cfg_ready_q <= cfg_ready_d;
         cen_q       <= cen_d;
         for (int i = 0; i < CHANNELS; i++) begin
            num_q[i] <= num_d[i];
            den_q[i] <= den_d[i];
            acc_q[i] <= acc_d[i];
         end
      end
   end

   assign cen       = cen_q;
   assign locked    = locked_q;
   assign cfg_ready = cfg_ready_q;

endmodule
